// File: rtl/dac_feedback_tx_pkg.sv
// dac_feedback_tx_pkg
//   Shared widths, DAC code constants and the transmit FSM state type for the
//   DAC feedback transmitter and its code converter.
package dac_feedback_tx_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DAC_W   = 14;
  localparam int unsigned FB_W    = 15;

  localparam logic [DAC_W-1:0] DAC_MIDSCALE = 14'h2000;
  localparam int               DAC_MAX_S    = 8191;
  localparam int               DAC_MIN_S    = -8192;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD
  } tx_state_e;

endpackage

// File: rtl/dac_feedback_tx_if.sv
// dac_feedback_tx_if
//   DAC-update strobe interface from the feedback calculation stage.
//   fb_word    : signed feedback word, valid while upd_strb is high
//   fb_oflow   : overflow flag qualified with fb_word
//   upd_strb   : DAC-update strobe (rising edge used)
//   store_strb : store/run enable, low forces an idle flush
//   master = calculation stage, slave = dac_feedback_tx
interface dac_feedback_tx_if;
  import dac_feedback_tx_pkg::*;

  logic [FB_W-1:0] fb_word;
  logic            fb_oflow;
  logic            upd_strb;
  logic            store_strb;

  modport master (output fb_word, output fb_oflow, output upd_strb, output store_strb);
  modport slave  (input  fb_word, input  fb_oflow, input  upd_strb, input  store_strb);

endinterface

// File: rtl/dac_feedback_tx_code_sat.sv
// dac_code_sat
//   Combinational conversion of a signed 15-bit feedback word into a 14-bit
//   offset-binary DAC code with clipping and overflow saturation.
//   fb_word_i  : signed feedback word
//   fb_oflow_i : overflow flag; saturates on the sign bit of fb_word_i
//   code_o     : offset-binary DAC code
module dac_code_sat
  import dac_feedback_tx_pkg::*;
(
  input  logic [FB_W-1:0]  fb_word_i,
  input  logic             fb_oflow_i,
  output logic [DAC_W-1:0] code_o
);

  localparam logic signed [FB_W-1:0] MAX_W = FB_W'(DAC_MAX_S);
  localparam logic signed [FB_W-1:0] MIN_W = FB_W'(DAC_MIN_S);

  logic signed [FB_W-1:0] word_s;
  logic [DAC_W-1:0]       clip;

  assign word_s = signed'(fb_word_i);

  always_comb begin
    clip = word_s[DAC_W-1:0];
    if (fb_oflow_i) begin
      clip = fb_word_i[FB_W-1] ? MIN_W[DAC_W-1:0] : MAX_W[DAC_W-1:0];
    end else if (word_s > MAX_W) begin
      clip = MAX_W[DAC_W-1:0];
    end else if (word_s < MIN_W) begin
      clip = MIN_W[DAC_W-1:0];
    end
    // two's complement -> offset binary
    code_o = {~clip[DAC_W-1], clip[DAC_W-2:0]};
  end

endmodule

// File: rtl/dac_feedback_tx.sv
// dac_feedback_tx
//   Captures feedback words on the rising edge of the DAC-update strobe,
//   converts them to offset-binary codes and shifts them to a serial DAC as
//   16-bit frames {CMD_BITS, code}, MSB first. One-entry pending buffer.
//   clk, rst_n : system clock, async active-low reset
//   fb         : DAC-update strobe interface (slave side)
//   dac_sclk   : serial clock, idle low
//   dac_sdi    : serial data, changes on sclk falling edges
//   dac_csn    : frame select, active low
//   busy       : frame load through end of CS hold
//   drop_cnt   : saturating count of overwritten pending words
//   ldac_n     : DAC load pulse, only when DAC_LDAC_EN is defined
//   last_code  : most recent code sent
module dac_feedback_tx
  import dac_feedback_tx_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned CS_HOLD  = 3,
  parameter logic [1:0]  CMD_BITS = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  dac_feedback_tx_if.slave fb,
  output logic             dac_sclk,
  output logic             dac_sdi,
  output logic             dac_csn,
  output logic             busy,
  output logic [7:0]       drop_cnt,
`ifdef DAC_LDAC_EN
  output logic             ldac_n,
`endif
  output logic [DAC_W-1:0] last_code
);

`ifdef DAC_LDAC_EN
  localparam int unsigned HOLD_CYC = (CS_HOLD < 3) ? 3 : CS_HOLD;
`else
  localparam int unsigned HOLD_CYC = CS_HOLD;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [3:0] DIV_LAST  = 4'(SCLK_DIV - 1);

  tx_state_e          state_q;
  logic               upd_q, store_q;
  logic [DAC_W-1:0]   pend_q, cur_code_q, last_code_q, code_d;
  logic               pend_vld_q;
  logic [FRAME_W-1:0] sh_q, frame_d;
  logic [3:0]         div_q;
  logic [4:0]         rises_q;
  logic [7:0]         hold_q, drop_q;
  logic               sclk_q, sdi_q, csn_q, busy_q;
  logic               cap_d, flush_d, start_d;
`ifdef DAC_LDAC_EN
  logic               ldac_q;
  assign ldac_n = ldac_q;
`endif

  dac_code_sat u_sat (
    .fb_word_i  (fb.fb_word),
    .fb_oflow_i (fb.fb_oflow),
    .code_o     (code_d)
  );

  always_comb begin
    cap_d   = fb.upd_strb & ~upd_q & fb.store_strb;
    flush_d = store_q & ~fb.store_strb;
    start_d = pend_vld_q & ((state_q == ST_IDLE) |
                            ((state_q == ST_HOLD) & (hold_q == HOLD_LAST)));
    frame_d = {CMD_BITS, pend_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      upd_q       <= 1'b0;
      store_q     <= 1'b0;
      pend_q      <= DAC_MIDSCALE;
      pend_vld_q  <= 1'b0;
      cur_code_q  <= DAC_MIDSCALE;
      last_code_q <= DAC_MIDSCALE;
      sh_q        <= '0;
      div_q       <= '0;
      rises_q     <= '0;
      hold_q      <= '0;
      drop_q      <= '0;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      csn_q       <= 1'b1;
      busy_q      <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_q      <= 1'b1;
`endif
    end else begin
      upd_q   <= fb.upd_strb;
      store_q <= fb.store_strb;

      // Pending buffer: a load this cycle consumes the old entry, so a
      // simultaneous capture refills it without counting a drop. A falling
      // store_strb replaces any pending word with one midscale request.
      if (cap_d) begin
        pend_q     <= code_d;
        pend_vld_q <= 1'b1;
        if (pend_vld_q && !start_d && (drop_q != 8'hFF)) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (flush_d) begin
        pend_q     <= DAC_MIDSCALE;
        pend_vld_q <= 1'b1;
      end else if (start_d) begin
        pend_vld_q <= 1'b0;
      end

      if (start_d) begin
        state_q    <= ST_LOAD;
        csn_q      <= 1'b0;
        busy_q     <= 1'b1;
        sclk_q     <= 1'b0;
        sdi_q      <= frame_d[FRAME_W-1];
        sh_q       <= {frame_d[FRAME_W-2:0], 1'b0};
        cur_code_q <= pend_q;
        div_q      <= '0;
        rises_q    <= '0;
      end else begin
        case (state_q)
          ST_LOAD, ST_SHIFT: begin
            // The LOAD cycle counts as the first cycle of the initial low phase.
            if (state_q == ST_LOAD) state_q <= ST_SHIFT;
            if (div_q == DIV_LAST) begin
              div_q <= '0;
              if (!sclk_q) begin
                sclk_q  <= 1'b1;
                rises_q <= rises_q + 5'd1;
              end else if (rises_q == 5'd16) begin
                sclk_q      <= 1'b0;
                sdi_q       <= 1'b0;
                csn_q       <= 1'b1;
                last_code_q <= cur_code_q;
                hold_q      <= '0;
                state_q     <= ST_HOLD;
              end else begin
                sclk_q <= 1'b0;
                sdi_q  <= sh_q[FRAME_W-1];
                sh_q   <= {sh_q[FRAME_W-2:0], 1'b0};
              end
            end else begin
              div_q <= div_q + 4'd1;
            end
          end
          ST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
          default: ;
        endcase
      end

`ifdef DAC_LDAC_EN
      // Low for the first two HOLD cycles after csn rises.
      if (state_q == ST_HOLD) begin
        if (hold_q == 8'd0) ldac_q <= 1'b0;
        else if (hold_q == 8'd2) ldac_q <= 1'b1;
      end
`endif
    end
  end

  assign dac_sclk  = sclk_q;
  assign dac_sdi   = sdi_q;
  assign dac_csn   = csn_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;
  assign last_code = last_code_q;

endmodule
